// File: rtl/event_encoder_16to4.sv
// 16-source event encoder: edge-detects level events into a pending bitmap and
// presents one encoded index at a time over a valid/ready handshake.

module event_encoder_lane (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic evt_i,
  input  logic acc_i,
  output logic pend_o,
  output logic ovf_o
);
  logic evt_q, evt_d;
  logic pend_q, pend_d;
  logic rise;

  assign rise = evt_i & ~evt_q;

  always_comb begin
    evt_d  = evt_i;
    // A rise on the bit being accepted re-arms it rather than being lost.
    pend_d = clear_i ? 1'b0 : ((pend_q & ~acc_i) | rise);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_q  <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      evt_q  <= evt_d;
      pend_q <= pend_d;
    end
  end

  assign pend_o = pend_q;
  assign ovf_o  = rise & pend_q & ~acc_i;
endmodule

module event_encoder_16to4 #(
  parameter bit RR_EN = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic [15:0] evt_in,
  output logic [3:0]  code_o,
  output logic        code_valid_o,
  input  logic        code_ready_i,
  output logic [15:0] pending_o,
  output logic        overflow_o
);
  localparam int NUM_LANES = 16;
  localparam int CODE_W    = 4;

  typedef enum logic {IDLE, PRESENT} state_e;

  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic              valid;
  } rsp_t;

  state_e                state_q, state_d;
  rsp_t                  rsp_q, rsp_d;
  logic [CODE_W-1:0]     last_q, last_d;
  logic                  ovf_q, ovf_d;
  logic [NUM_LANES-1:0]  pend, ovf_vec, acc_vec;
  logic                  accept;
  logic [CODE_W-1:0]     start, idx, sel;
  logic                  found;

  assign accept  = rsp_q.valid & code_ready_i;
  assign acc_vec = accept ? (NUM_LANES'(1) << rsp_q.code) : '0;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    event_encoder_lane u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear_i (clear_i),
      .evt_i   (evt_in[g]),
      .acc_i   (acc_vec[g]),
      .pend_o  (pend[g]),
      .ovf_o   (ovf_vec[g])
    );
  end

  // Circular scan; fixed priority is just a scan that always starts at 0.
  always_comb begin
    start = RR_EN ? (last_q + CODE_W'(1)) : '0;
    sel   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      idx = start + CODE_W'(i);
      if (!found && pend[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rsp_d   = rsp_q;
    last_d  = last_q;
    ovf_d   = ovf_q | (|ovf_vec);
    if (clear_i) begin
      state_d = IDLE;
      rsp_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (found) begin
          rsp_d.code  = sel;
          rsp_d.valid = 1'b1;
          state_d     = PRESENT;
        end
        PRESENT: if (accept) begin
          rsp_d.valid = 1'b0;
          last_d      = rsp_q.code;
          state_d     = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rsp_q   <= '0;
      last_q  <= CODE_W'(NUM_LANES - 1);
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rsp_q   <= rsp_d;
      last_q  <= last_d;
      ovf_q   <= ovf_d;
    end
  end

  assign code_o       = rsp_q.code;
  assign code_valid_o = rsp_q.valid;
  assign pending_o    = pend;
  assign overflow_o   = ovf_q;
endmodule
